pkt_bufid_refcnt_manager: RTL and testbench

Owns the per-buffer reference counts of the centralized packet buffer. It loads a count when the forward-action stage reports how many copies of a bufid were dispatched. It arbitrates bufid release requests from output ports p0-p7 and the host path, one per cycle, round-robin. When a count reaches zero it returns the bufid to the free-bufid pool.

---
 rtl/pkt_bufid_refcnt_manager.sv | 140 ++++++++++++++
 tb/tb_pkt_bufid_refcnt_manager.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pkt_bufid_refcnt_manager.sv
// Per-bufid reference-count table with round-robin release arbitration over
// ports p0-p7 and host; a bufid whose count reaches zero is returned to the free pool.
module pkt_bufid_refcnt_manager #(
  parameter int BUFID_W = 9,
  parameter int CNT_W   = 4,
  parameter int ERR_W   = 8,
  parameter int NREQ    = 9
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [BUFID_W-1:0] iv_pkt_bufid,
  input  logic               i_pkt_bufid_wr,
  input  logic [CNT_W-1:0]   iv_pkt_bufid_cnt,
  input  logic [BUFID_W-1:0] iv_release_bufid_p0,
  input  logic               i_release_wr_p0,
  input  logic [BUFID_W-1:0] iv_release_bufid_p1,
  input  logic               i_release_wr_p1,
  input  logic [BUFID_W-1:0] iv_release_bufid_p2,
  input  logic               i_release_wr_p2,
  input  logic [BUFID_W-1:0] iv_release_bufid_p3,
  input  logic               i_release_wr_p3,
  input  logic [BUFID_W-1:0] iv_release_bufid_p4,
  input  logic               i_release_wr_p4,
  input  logic [BUFID_W-1:0] iv_release_bufid_p5,
  input  logic               i_release_wr_p5,
  input  logic [BUFID_W-1:0] iv_release_bufid_p6,
  input  logic               i_release_wr_p6,
  input  logic [BUFID_W-1:0] iv_release_bufid_p7,
  input  logic               i_release_wr_p7,
  input  logic [BUFID_W-1:0] iv_release_bufid_host,
  input  logic               i_release_wr_host,
  output logic [BUFID_W-1:0] ov_free_bufid,
  output logic               o_free_bufid_wr,
  output logic [NREQ-1:0]    ov_pending,
  output logic [ERR_W-1:0]   ov_overflow_cnt,
  output logic [ERR_W-1:0]   ov_underflow_cnt,
  output logic [ERR_W-1:0]   ov_zero_load_cnt
);

  localparam int DEPTH = 2**BUFID_W;
  localparam int PTR_W = 4;

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a, input logic [1:0] inc);
    logic [ERR_W:0] s;
    s = {1'b0, a} + {{(ERR_W-1){1'b0}}, inc};
    return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

  logic [BUFID_W-1:0] rel_bufid [NREQ];
  logic [NREQ-1:0]    rel_wr;
  logic [BUFID_W-1:0] held_bufid [NREQ];
  logic [NREQ-1:0]    pend;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   tbl [DEPTH];

  assign rel_bufid[0] = iv_release_bufid_p0;
  assign rel_bufid[1] = iv_release_bufid_p1;
  assign rel_bufid[2] = iv_release_bufid_p2;
  assign rel_bufid[3] = iv_release_bufid_p3;
  assign rel_bufid[4] = iv_release_bufid_p4;
  assign rel_bufid[5] = iv_release_bufid_p5;
  assign rel_bufid[6] = iv_release_bufid_p6;
  assign rel_bufid[7] = iv_release_bufid_p7;
  assign rel_bufid[8] = iv_release_bufid_host;
  assign rel_wr = {i_release_wr_host, i_release_wr_p7, i_release_wr_p6, i_release_wr_p5,
                   i_release_wr_p4, i_release_wr_p3, i_release_wr_p2, i_release_wr_p1,
                   i_release_wr_p0};

  // Stage p0: round-robin grant and table lookup, all combinational
  logic               gnt_vld_p0;
  logic [PTR_W-1:0]   gnt_idx_p0;
  logic [PTR_W:0]     cand;
  logic [NREQ-1:0]    gnt_mask_p0;
  logic [BUFID_W-1:0] gnt_bufid_p0;
  logic [CNT_W-1:0]   cnt_rd_p0;
  logic               ld_eff_p0, collide_p0, rel_ok_p0, uf_rel_p0, ovf_any_p0;

  always_comb begin
    gnt_vld_p0 = 1'b0;
    gnt_idx_p0 = ptr;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NREQ)) cand = cand - (PTR_W+1)'(NREQ);
      if (!gnt_vld_p0 && pend[cand[PTR_W-1:0]]) begin
        gnt_vld_p0 = 1'b1;
        gnt_idx_p0 = cand[PTR_W-1:0];
      end
    end
  end

  assign gnt_mask_p0  = gnt_vld_p0 ? (NREQ'(1) << gnt_idx_p0) : '0;
  assign gnt_bufid_p0 = held_bufid[gnt_idx_p0];
  assign cnt_rd_p0    = tbl[gnt_bufid_p0];
  assign ld_eff_p0    = i_pkt_bufid_wr && (iv_pkt_bufid_cnt != '0);
  // A load to the bufid being released overrides the release entirely
  assign collide_p0   = gnt_vld_p0 && ld_eff_p0 && (iv_pkt_bufid == gnt_bufid_p0);
  assign rel_ok_p0    = gnt_vld_p0 && !collide_p0;
  assign uf_rel_p0    = rel_ok_p0 && (cnt_rd_p0 == '0);
  assign ovf_any_p0   = |(rel_wr & pend & ~gnt_mask_p0);

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NREQ; k++)
      if (rel_wr[k] && (!pend[k] || gnt_mask_p0[k])) held_bufid[k] <= rel_bufid[k];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      if (rel_ok_p0 && (cnt_rd_p0 != '0)) tbl[gnt_bufid_p0] <= cnt_rd_p0 - CNT_W'(1);
      if (ld_eff_p0) tbl[iv_pkt_bufid] <= iv_pkt_bufid_cnt;
    end
  end

  // Stage p1: registered free strobe, pending flags, pointer and error counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend             <= '0;
      ptr              <= PTR_W'(NREQ - 1);
      o_free_bufid_wr  <= 1'b0;
      ov_free_bufid    <= '0;
      ov_overflow_cnt  <= '0;
      ov_underflow_cnt <= '0;
      ov_zero_load_cnt <= '0;
    end else begin
      pend <= (pend & ~gnt_mask_p0) | rel_wr;
      if (gnt_vld_p0) ptr <= gnt_idx_p0;
      o_free_bufid_wr  <= rel_ok_p0 && (cnt_rd_p0 == CNT_W'(1));
      ov_free_bufid    <= (rel_ok_p0 && (cnt_rd_p0 == CNT_W'(1))) ? gnt_bufid_p0 : '0;
      ov_overflow_cnt  <= sat_add(ov_overflow_cnt, {1'b0, ovf_any_p0});
      ov_underflow_cnt <= sat_add(ov_underflow_cnt, 2'(uf_rel_p0) + 2'(collide_p0));
      ov_zero_load_cnt <= sat_add(ov_zero_load_cnt,
                                  {1'b0, i_pkt_bufid_wr && (iv_pkt_bufid_cnt == '0)});
    end
  end

  assign ov_pending = pend;

endmodule

// File: tb/tb_pkt_bufid_refcnt_manager.sv
// Directed bench for pkt_bufid_refcnt_manager with hand-computed expectations.
`timescale 1ns/1ps
module tb_pkt_bufid_refcnt_manager;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] ld_bufid = '0;
  logic       ld_wr = 1'b0;
  logic [3:0] ld_cnt = '0;
  logic [8:0] rb [9];
  logic [8:0] rw = '0;
  logic [8:0] free_bufid;
  logic       free_wr;
  logic [8:0] pending;
  logic [7:0] ovf, uf, zl;
  int         errors = 0;
  int         checks = 0;

  always #4 clk = ~clk;

  pkt_bufid_refcnt_manager dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_pkt_bufid(ld_bufid), .i_pkt_bufid_wr(ld_wr), .iv_pkt_bufid_cnt(ld_cnt),
    .iv_release_bufid_p0(rb[0]), .i_release_wr_p0(rw[0]),
    .iv_release_bufid_p1(rb[1]), .i_release_wr_p1(rw[1]),
    .iv_release_bufid_p2(rb[2]), .i_release_wr_p2(rw[2]),
    .iv_release_bufid_p3(rb[3]), .i_release_wr_p3(rw[3]),
    .iv_release_bufid_p4(rb[4]), .i_release_wr_p4(rw[4]),
    .iv_release_bufid_p5(rb[5]), .i_release_wr_p5(rw[5]),
    .iv_release_bufid_p6(rb[6]), .i_release_wr_p6(rw[6]),
    .iv_release_bufid_p7(rb[7]), .i_release_wr_p7(rw[7]),
    .iv_release_bufid_host(rb[8]), .i_release_wr_host(rw[8]),
    .ov_free_bufid(free_bufid), .o_free_bufid_wr(free_wr), .ov_pending(pending),
    .ov_overflow_cnt(ovf), .ov_underflow_cnt(uf), .ov_zero_load_cnt(zl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [8:0] b, input logic [3:0] c);
    ld_wr = 1'b1; ld_bufid = b; ld_cnt = c;
    tick();
    ld_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 9; k++) rb[k] = '0;
    repeat (3) tick();
    chk("rst_free_wr", 32'(free_wr), 0);
    chk("rst_free_bufid", 32'(free_bufid), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_uf", 32'(uf), 0);
    chk("rst_zl", 32'(zl), 0);
    rst_n = 1'b1;
    tick();

    // traffic, then asynchronous reset in the middle of a cycle
    rw = '1;
    for (int k = 0; k < 9; k++) rb[k] = 9'd7;
    tick();
    rw = '0;
    chk("mid_pending", 32'(pending), 32'h1ff);
    tick();
    chk("mid_uf", 32'(uf), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_pending", 32'(pending), 0);
    chk("arst_uf", 32'(uf), 0);
    chk("arst_free_wr", 32'(free_wr), 0);
    rst_n = 1'b1;
    tick();
    rw[0] = 1'b1; rb[0] = 9'd7;
    tick();
    rw[0] = 1'b0;
    tick();
    chk("post_rst_uf", 32'(uf), 1);
    chk("post_rst_free_wr", 32'(free_wr), 0);
    tick();
    chk("post_rst_free_wr2", 32'(free_wr), 0);

    // three releases of a cnt=3 bufid
    do_reset();
    load(9'd5, 4'd3);
    rw[2:0] = 3'b111; rb[0] = 9'd5; rb[1] = 9'd5; rb[2] = 9'd5;
    tick();
    rw = '0;
    chk("rc_pend0", 32'(pending), 7);
    tick();
    chk("rc_pend1", 32'(pending), 6);
    chk("rc_free1", 32'(free_wr), 0);
    tick();
    chk("rc_pend2", 32'(pending), 4);
    chk("rc_free2", 32'(free_wr), 0);
    tick();
    chk("rc_free3", 32'(free_wr), 1);
    chk("rc_bufid3", 32'(free_bufid), 5);
    chk("rc_pend3", 32'(pending), 0);
    tick();
    chk("rc_free4", 32'(free_wr), 0);
    chk("rc_bufid4", 32'(free_bufid), 0);

    // fairness with all nine requesters pending
    do_reset();
    for (int k = 0; k < 9; k++) load(9'(20 + k), 4'd1);
    rw = '1;
    for (int k = 0; k < 9; k++) rb[k] = 9'(20 + k);
    tick();
    rw = '0;
    for (int i = 0; i < 18; i++) begin
      if (i < 9) begin
        rw[i] = 1'b1; rb[i] = 9'(40 + i);
      end
      tick();
      rw = '0;
      chk("rr_free_wr", 32'(free_wr), (i < 9) ? 1 : 0);
      chk("rr_free_bufid", 32'(free_bufid), (i < 9) ? 32'(20 + i) : 0);
      chk("rr_pending", 32'(pending),
          (i < 9) ? 32'h1ff : (32'h1ff & ~((32'd2 << (i - 9)) - 1)));
    end
    chk("rr_ovf", 32'(ovf), 0);
    chk("rr_uf", 32'(uf), 9);

    // overflow on p3 while p0 holds an older request
    load(9'd30, 4'd1);
    load(9'd31, 4'd1);
    rw[0] = 1'b1; rb[0] = 9'd31; rw[3] = 1'b1; rb[3] = 9'd30;
    tick();
    rw[0] = 1'b0; rb[3] = 9'd33;
    tick();
    rw[3] = 1'b0;
    chk("ovf_cnt", 32'(ovf), 1);
    chk("ovf_free_p0", 32'(free_bufid), 31);
    chk("ovf_pending", 32'(pending), 8);
    tick();
    chk("ovf_free_wr", 32'(free_wr), 1);
    chk("ovf_kept_bufid", 32'(free_bufid), 30);

    // load/release collision on bufid 9
    load(9'd9, 4'd1);
    rw[0] = 1'b1; rb[0] = 9'd9;
    tick();
    rw[0] = 1'b0;
    load(9'd9, 4'd2);
    chk("col_free_wr", 32'(free_wr), 0);
    chk("col_uf", 32'(uf), 10);
    rw[1] = 1'b1; rb[1] = 9'd9;
    tick();
    rw[1] = 1'b0;
    tick();
    chk("col_rel1_free_wr", 32'(free_wr), 0);
    rw[1] = 1'b1;
    tick();
    rw[1] = 1'b0;
    tick();
    chk("col_rel2_free_wr", 32'(free_wr), 1);
    chk("col_rel2_bufid", 32'(free_bufid), 9);

    // zero-count load leaves the table alone
    load(9'd12, 4'd1);
    load(9'd12, 4'd0);
    chk("zl_cnt", 32'(zl), 1);
    rw[1] = 1'b1; rb[1] = 9'd12;
    tick();
    rw[1] = 1'b0;
    tick();
    chk("zl_free_wr", 32'(free_wr), 1);
    chk("zl_free_bufid", 32'(free_bufid), 12);

    // underflow counter saturation
    rw[0] = 1'b1; rb[0] = 9'd100;
    repeat (300) tick();
    rw[0] = 1'b0;
    tick();
    tick();
    chk("sat_uf", 32'(uf), 255);
    chk("sat_ovf", 32'(ovf), 1);
    chk("sat_pending", 32'(pending), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
